// File: rtl/br_resolve_unit.sv
`default_nettype none
// ============================================================================
// br_resolve_unit : checks fetch-time branch predictions against execute-time
//                   outcomes, trains the predictor and redirects on mispredict.
// Optional macro BR_RESOLVE_PERF_EN adds perf_br / perf_mis counters.
// Revision: 1.0
// ============================================================================
module br_resolve_unit #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        f_valid,
   input  logic [31:0] f_pc,
   input  logic        f_pred_taken,
   input  logic [31:0] f_pred_target,
   output logic        f_ready,
   input  logic        e_valid,
   input  logic [31:0] e_pc,
   input  logic        e_is_br,
   input  logic        e_taken,
   input  logic [31:0] e_target,
   output logic        upd_valid,
   output logic [31:0] upd_pc,
   output logic        upd_taken,
   output logic [31:0] upd_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        err
`ifdef BR_RESOLVE_PERF_EN
   ,
   output logic [31:0] perf_br,
   output logic [31:0] perf_mis
`endif
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_FL_W  = $clog2(FLUSH_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT  = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
   localparam logic [c_FL_W-1:0]  c_FLUSH_LOAD = c_FL_W'(FLUSH_CYCLES - 1);
   localparam logic [c_FL_W-1:0]  c_FL_ONE     = c_FL_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]        r_pc_mem  [DEPTH];
   logic               r_pt_mem  [DEPTH];
   logic [31:0]        r_tgt_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [c_FL_W-1:0]  r_flush_cnt;

   logic        r_upd_valid;
   logic [31:0] r_upd_pc;
   logic        r_upd_taken;
   logic [31:0] r_upd_target;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;
   logic        r_err;

   logic        w_ready;
   logic        w_flush;
   logic        w_push;
   logic        w_pop;
   logic        w_empty_pop;
   logic        w_pc_mismatch;
   logic        w_mispredict;
   logic        w_act_taken;
   logic [31:0] w_next_pc;
   logic [31:0] w_head_pc;
   logic        w_head_taken;
   logic [31:0] w_head_target;

   assign w_head_pc     = r_pc_mem[r_rd_ptr];
   assign w_head_taken  = r_pt_mem[r_rd_ptr];
   assign w_head_target = r_tgt_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ready       = 1'b0;
      w_flush       = 1'b0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_empty_pop   = 1'b0;
      w_pc_mismatch = 1'b0;
      w_mispredict  = 1'b0;
      w_act_taken   = e_is_br & e_taken;
      w_next_pc     = w_act_taken ? e_target : (e_pc + 32'd4);
      case (r_state)
         ST_IDLE: begin
            w_ready = (r_count < c_DEPTH_CNT);
            w_push  = f_valid & w_ready;
            if (e_valid) begin
               if (r_count == '0) begin
                  w_empty_pop = 1'b1;
               end else begin
                  w_pop         = 1'b1;
                  w_pc_mismatch = (e_pc != w_head_pc);
                  // A PC mismatch means the queue is out of step with execute;
                  // redirecting is the only safe recovery.
                  w_mispredict  = w_pc_mismatch
                                | (w_head_taken != w_act_taken)
                                | (w_head_taken & e_taken & (w_head_target != e_target));
               end
            end
            if (w_mispredict) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_flush = 1'b1;
            if (r_flush_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Payload storage carries no reset; validity is tracked by pointers/count.
   always_ff @(posedge clk) begin
      if (w_push && !w_mispredict) begin
         r_pc_mem[r_wr_ptr]  <= f_pc;
         r_pt_mem[r_wr_ptr]  <= f_pred_taken;
         r_tgt_mem[r_wr_ptr] <= f_pred_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_flush_cnt <= '0;
      end else if (w_mispredict) begin
         // Wrong-path push in the same cycle is dropped along with the queue.
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_flush_cnt <= c_FLUSH_LOAD;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - c_FL_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_upd_valid      <= 1'b0;
         r_upd_pc         <= '0;
         r_upd_taken      <= 1'b0;
         r_upd_target     <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_err            <= 1'b0;
      end else begin
         r_upd_valid      <= w_pop & e_is_br;
         r_redirect_valid <= w_mispredict;
         if (w_pop && e_is_br) begin
            r_upd_pc     <= e_pc;
            r_upd_taken  <= e_taken;
            r_upd_target <= e_target;
         end
         if (w_mispredict) begin
            r_redirect_pc <= w_next_pc;
         end
         if (w_empty_pop || (w_pop && w_pc_mismatch)) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef BR_RESOLVE_PERF_EN
   logic [31:0] r_perf_br;
   logic [31:0] r_perf_mis;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_br  <= '0;
         r_perf_mis <= '0;
      end else begin
         if (w_pop && e_is_br && (r_perf_br != 32'hFFFF_FFFF)) begin
            r_perf_br <= r_perf_br + 32'd1;
         end
         if (w_mispredict && (r_perf_mis != 32'hFFFF_FFFF)) begin
            r_perf_mis <= r_perf_mis + 32'd1;
         end
      end
   end

   assign perf_br  = r_perf_br;
   assign perf_mis = r_perf_mis;
`endif

   assign f_ready        = w_ready;
   assign flush          = w_flush;
   assign upd_valid      = r_upd_valid;
   assign upd_pc         = r_upd_pc;
   assign upd_taken      = r_upd_taken;
   assign upd_target     = r_upd_target;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign err            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_br_resolve_unit.sv
`default_nettype none
// ============================================================================
// tb_br_resolve_unit : directed and randomized checks of br_resolve_unit
//                      against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_br_resolve_unit;

   localparam int DEPTH        = 4;
   localparam int FLUSH_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_valid;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic [31:0] f_pred_target;
   logic        f_ready;
   logic        e_valid;
   logic [31:0] e_pc;
   logic        e_is_br;
   logic        e_taken;
   logic [31:0] e_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        err;
`ifdef BR_RESOLVE_PERF_EN
   logic [31:0] perf_br;
   logic [31:0] perf_mis;
`endif

   br_resolve_unit #(
      .DEPTH        (DEPTH),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .f_valid        (f_valid),
      .f_pc           (f_pc),
      .f_pred_taken   (f_pred_taken),
      .f_pred_target  (f_pred_target),
      .f_ready        (f_ready),
      .e_valid        (e_valid),
      .e_pc           (e_pc),
      .e_is_br        (e_is_br),
      .e_taken        (e_taken),
      .e_target       (e_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .err            (err)
`ifdef BR_RESOLVE_PERF_EN
      ,
      .perf_br        (perf_br),
      .perf_mis       (perf_mis)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tgt;
   } ent_t;

   ent_t        mq[$];
   int          m_flush_left;
   bit          m_err;
   bit          m_upd_valid;
   logic [31:0] m_upd_pc;
   bit          m_upd_taken;
   logic [31:0] m_upd_target;
   bit          m_rv;
   logic [31:0] m_rpc;
   logic [31:0] m_pbr;
   logic [31:0] m_pmis;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_flush_left = 0;
      m_err        = 1'b0;
      m_upd_valid  = 1'b0;
      m_rv         = 1'b0;
      m_rpc        = '0;
      m_pbr        = '0;
      m_pmis       = '0;
   endtask

   // One clock: apply inputs, check combinational outputs, advance the model,
   // then check the registered outputs after the edge.
   task automatic cyc(input logic fv, input logic [31:0] fpc, input logic fpt,
                      input logic [31:0] ftg, input logic ev, input logic [31:0] epc,
                      input logic ebr, input logic etk, input logic [31:0] etg);
      bit   rdy;
      bit   mis;
      bit   do_push;
      ent_t h;
      ent_t n;
      @(negedge clk);
      f_valid = fv; f_pc = fpc; f_pred_taken = fpt; f_pred_target = ftg;
      e_valid = ev; e_pc = epc; e_is_br = ebr; e_taken = etk; e_target = etg;
      #1;
      rdy = (mq.size() < DEPTH) && (m_flush_left == 0);
      check("f_ready", {31'd0, f_ready}, {31'd0, rdy});
      check("flush", {31'd0, flush}, {31'd0, (m_flush_left > 0)});
      do_push     = fv && rdy;
      m_upd_valid = 1'b0;
      m_rv        = 1'b0;
      if (m_flush_left > 0) begin
         m_flush_left--;
      end else begin
         if (ev) begin
            if (mq.size() == 0) begin
               m_err = 1'b1;
            end else begin
               h   = mq.pop_front();
               mis = 1'b0;
               if (h.pc != epc) begin
                  m_err = 1'b1;
                  mis   = 1'b1;
               end
               if (h.pt != (ebr && etk)) mis = 1'b1;
               if (h.pt && etk && (h.tgt != etg)) mis = 1'b1;
               if (ebr) begin
                  m_upd_valid  = 1'b1;
                  m_upd_pc     = epc;
                  m_upd_taken  = etk;
                  m_upd_target = etg;
                  if (m_pbr != 32'hFFFF_FFFF) m_pbr++;
               end
               if (mis) begin
                  m_rv  = 1'b1;
                  m_rpc = (ebr && etk) ? etg : epc + 32'd4;
                  mq.delete();
                  m_flush_left = FLUSH_CYCLES;
                  do_push      = 1'b0;
                  if (m_pmis != 32'hFFFF_FFFF) m_pmis++;
               end
            end
         end
         if (do_push) begin
            n.pc = fpc; n.pt = fpt; n.tgt = ftg;
            mq.push_back(n);
         end
      end
      @(posedge clk);
      #1;
      check("upd_valid", {31'd0, upd_valid}, {31'd0, m_upd_valid});
      if (m_upd_valid) begin
         check("upd_pc", upd_pc, m_upd_pc);
         check("upd_taken", {31'd0, upd_taken}, {31'd0, m_upd_taken});
         check("upd_target", upd_target, m_upd_target);
      end
      check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      check("redirect_pc", redirect_pc, m_rpc);
      check("err", {31'd0, err}, {31'd0, m_err});
`ifdef BR_RESOLVE_PERF_EN
      check("perf_br", perf_br, m_pbr);
      check("perf_mis", perf_mis, m_pmis);
`endif
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
      cyc(1, pc, pt, tg, 0, 0, 0, 0, 0);
   endtask

   task automatic pop(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tg);
      cyc(0, 0, 0, 0, 1, pc, br, tk, tg);
   endtask

   logic [31:0] r_fpc, r_ftg, r_epc, r_etg;
   logic        r_fv, r_fpt, r_ev, r_ebr, r_etk;
   ent_t        rh;

   initial begin
      rst = 1'b1;
      f_valid = 0; f_pc = 0; f_pred_taken = 0; f_pred_target = 0;
      e_valid = 0; e_pc = 0; e_is_br = 0; e_taken = 0; e_target = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_f_ready", {31'd0, f_ready}, 32'd1);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
      check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;

      // Correctly predicted not-taken branch trains without redirect.
      push(32'h100, 0, 32'h0);
      pop(32'h100, 1, 0, 32'h104);
      idle(1);

      // Taken with wrong target: redirect to resolved target and flush.
      push(32'h200, 1, 32'h300);
      pop(32'h200, 1, 1, 32'h340);
      idle(3);

      // Predicted taken but not a branch: fall-through redirect, no training.
      push(32'h400, 1, 32'h480);
      pop(32'h400, 0, 0, 32'h0);
      idle(3);

      // Fall-through wraps modulo 2^32.
      push(32'hFFFF_FFFC, 1, 32'h10);
      pop(32'hFFFF_FFFC, 0, 0, 32'h0);
      idle(3);

      // Fill, push+pop at full and near full, drain across pointer wrap.
      push(32'h500, 0, 0);
      push(32'h504, 0, 0);
      push(32'h508, 0, 0);
      push(32'h50C, 0, 0);
      cyc(1, 32'h510, 0, 0, 1, 32'h500, 0, 0, 0);
      cyc(1, 32'h514, 0, 0, 1, 32'h504, 1, 0, 0);
      cyc(1, 32'h518, 0, 0, 1, 32'h508, 1, 0, 0);
      pop(32'h50C, 1, 0, 0);
      pop(32'h514, 1, 0, 0);
      pop(32'h518, 1, 0, 0);
      idle(1);

      // Push discarded when it coincides with a mispredicted pop.
      push(32'h600, 0, 0);
      cyc(1, 32'h604, 0, 0, 1, 32'h600, 1, 1, 32'h700);
      idle(3);
      pop(32'h604, 0, 0, 0);

      // Sticky error, then asynchronous reset in the middle of a flush.
      idle(2);
      push(32'h800, 1, 32'h900);
      pop(32'h800, 1, 0, 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("arst_flush", {31'd0, flush}, 32'd0);
      check("arst_f_ready", {31'd0, f_ready}, 32'd1);
      check("arst_err", {31'd0, err}, 32'd0);
      check("arst_redirect_pc", redirect_pc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pop(32'h800, 1, 0, 0);
      idle(1);

      rst = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 600; i++) begin
         r_fv  = 1'($urandom_range(0, 1));
         r_fpc = $urandom & 32'hFFFF_FFFC;
         r_fpt = 1'($urandom_range(0, 1));
         r_ftg = $urandom & 32'hFFFF_FFFC;
         r_ev  = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0) begin
            rh    = mq[0];
            r_epc = ($urandom_range(0, 31) == 0) ? rh.pc + 32'd4 : rh.pc;
            r_ebr = rh.pt ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            r_etk = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : rh.pt;
            r_etg = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : rh.tgt;
         end else begin
            r_epc = $urandom & 32'hFFFF_FFFC;
            r_ebr = 1'($urandom_range(0, 1));
            r_etk = 1'($urandom_range(0, 1));
            r_etg = $urandom & 32'hFFFF_FFFC;
            r_ev  = ($urandom_range(0, 9) == 0);
         end
         cyc(r_fv, r_fpc, r_fpt, r_ftg, r_ev, r_epc, r_ebr, r_etk, r_etg);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
